// File: rtl/l3_cache_ctrl.sv
// rtl/l3_cache_ctrl.sv - two-port round-robin sequencer for the L3 data cache (optional counters: L3_CTRL_PERF_EN)
module l3_cache_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid_i,
    input  logic [ADDR_WIDTH-1:0] req0_addr_i,
    input  logic                  req0_wr_en_i,
    input  logic [DATA_WIDTH-1:0] req0_wr_data_i,
    input  logic [3:0]            req0_byte_en_i,
    output logic                  req0_done_o,
    output logic [DATA_WIDTH-1:0] req0_rd_data_o,
    output logic                  req0_err_o,
    input  logic                  req1_valid_i,
    input  logic [ADDR_WIDTH-1:0] req1_addr_i,
    input  logic                  req1_wr_en_i,
    input  logic [DATA_WIDTH-1:0] req1_wr_data_i,
    input  logic [3:0]            req1_byte_en_i,
    output logic                  req1_done_o,
    output logic [DATA_WIDTH-1:0] req1_rd_data_o,
    output logic                  req1_err_o,
    output logic [ADDR_WIDTH-1:0] cache_addr_o,
    output logic                  cache_wr_en_o,
    output logic [DATA_WIDTH-1:0] cache_wr_data_o,
    output logic [3:0]            cache_byte_en_o,
    output logic                  cache_mem_valid_o,
    output logic [DATA_WIDTH-1:0] cache_mem_data_o,
    input  logic                  cache_hit_i,
    input  logic [DATA_WIDTH-1:0] cache_rd_data_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_byte_en_o,
    output logic [DATA_WIDTH-1:0] mem_wr_data_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_i
`ifdef L3_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_hit_cnt_o,
    output logic [31:0]           perf_miss_cnt_o,
    output logic [31:0]           perf_stall_cnt_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_MEM_RD, S_FILL, S_MEM_WR, S_RESP
    } state_t;

    localparam logic [DATA_WIDTH-1:0] MASK_B = DATA_WIDTH'(8'hFF);
    localparam logic [DATA_WIDTH-1:0] MASK_H = DATA_WIDTH'(16'hFFFF);

    state_t                state_q, state_d;
    logic                  rr_q, rr_d;
    logic                  port_q, port_d;
    logic                  wr_q, wr_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] mdata_q, mdata_d;
    logic                  sel;
    logic [3:0]            sel_be;
    logic                  gnt0, gnt1;
    logic [DATA_WIDTH-1:0] fill_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rr_q    <= 1'b0;
            port_q  <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            mdata_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            port_q  <= port_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            mdata_q <= mdata_d;
        end
    end

    always_comb begin
        case (be_q)
            4'b0001: fill_mask = MASK_B;
            4'b0011: fill_mask = MASK_H;
            default: fill_mask = '1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        port_d  = port_q;
        wr_d    = wr_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        mdata_d = mdata_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        sel     = (req0_valid_i && req1_valid_i) ? rr_q : req1_valid_i;
        sel_be  = sel ? req1_byte_en_i : req0_byte_en_i;
        case (state_q)
            S_IDLE: begin
                if (req0_valid_i || req1_valid_i) begin
                    gnt0    = ~sel;
                    gnt1    = sel;
                    port_d  = sel;
                    rr_d    = ~sel;
                    addr_d  = sel ? req1_addr_i : req0_addr_i;
                    wr_d    = sel ? req1_wr_en_i : req0_wr_en_i;
                    wdata_d = sel ? req1_wr_data_i : req0_wr_data_i;
                    be_d    = sel_be;
                    rdata_d = '0;
                    err_d   = !(sel_be == 4'b0001 || sel_be == 4'b0011 || sel_be == 4'b1111);
                    state_d = err_d ? S_RESP : S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (!cache_hit_i) begin
                    state_d = S_MEM_RD;
                end else if (wr_q) begin
                    state_d = S_MEM_WR;
                end else begin
                    rdata_d = cache_rd_data_i;
                    state_d = S_RESP;
                end
            end
            S_MEM_RD: begin
                if (mem_ack_i) begin
                    mdata_d = mem_rd_data_i;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (wr_q) begin
                    state_d = S_MEM_WR;
                end else begin
                    rdata_d = mdata_q & fill_mask;
                    state_d = S_RESP;
                end
            end
            S_MEM_WR: if (mem_ack_i) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // All outputs decode registered state, so reset clears them without waiting for a clock.
    logic cache_act, mem_act, resp0, resp1;
    assign cache_act = (state_q == S_LOOKUP) || (state_q == S_FILL);
    assign mem_act   = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign resp0     = (state_q == S_RESP) && !port_q;
    assign resp1     = (state_q == S_RESP) && port_q;

    assign cache_addr_o      = cache_act ? addr_q : '0;
    assign cache_wr_en_o     = cache_act && wr_q;
    assign cache_wr_data_o   = cache_act ? wdata_q : '0;
    assign cache_byte_en_o   = cache_act ? be_q : 4'b0000;
    assign cache_mem_valid_o = (state_q == S_FILL);
    assign cache_mem_data_o  = (state_q == S_FILL) ? mdata_q : '0;

    assign mem_req_o     = mem_act;
    assign mem_we_o      = (state_q == S_MEM_WR);
    assign mem_addr_o    = mem_act ? addr_q : '0;
    assign mem_byte_en_o = (state_q == S_MEM_WR) ? be_q : (mem_act ? 4'b1111 : 4'b0000);
    assign mem_wr_data_o = (state_q == S_MEM_WR) ? wdata_q : '0;

    assign req0_done_o    = resp0;
    assign req0_err_o     = resp0 && err_q;
    assign req0_rd_data_o = resp0 ? rdata_q : '0;
    assign req1_done_o    = resp1;
    assign req1_err_o     = resp1 && err_q;
    assign req1_rd_data_o = resp1 ? rdata_q : '0;

`ifdef L3_CTRL_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, stall_cnt_q, stall_cnt_d;
    logic        stall;

    always_comb begin
        stall       = (req0_valid_i && !(gnt0 || resp0)) || (req1_valid_i && !(gnt1 || resp1));
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (state_q == S_LOOKUP && cache_hit_i && hit_cnt_q != '1)   hit_cnt_d   = hit_cnt_q + 32'd1;
        if (state_q == S_LOOKUP && !cache_hit_i && miss_cnt_q != '1) miss_cnt_d  = miss_cnt_q + 32'd1;
        if (stall && stall_cnt_q != '1)                              stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_hit_cnt_o   = hit_cnt_q;
    assign perf_miss_cnt_o  = miss_cnt_q;
    assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_l3_cache_ctrl.sv
// tb/tb_l3_cache_ctrl.sv - scoreboard bench for l3_cache_ctrl with directed request vectors
module tb_l3_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid_i = 0, req0_wr_en_i = 0;
    logic [31:0] req0_addr_i = 0, req0_wr_data_i = 0;
    logic [3:0]  req0_byte_en_i = 0;
    logic        req0_done_o, req0_err_o;
    logic [31:0] req0_rd_data_o;
    logic        req1_valid_i = 0, req1_wr_en_i = 0;
    logic [31:0] req1_addr_i = 0, req1_wr_data_i = 0;
    logic [3:0]  req1_byte_en_i = 0;
    logic        req1_done_o, req1_err_o;
    logic [31:0] req1_rd_data_o;
    logic [31:0] cache_addr_o, cache_wr_data_o, cache_mem_data_o;
    logic        cache_wr_en_o, cache_mem_valid_o;
    logic [3:0]  cache_byte_en_o;
    logic        cache_hit_i = 0;
    logic [31:0] cache_rd_data_i = 0;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wr_data_o;
    logic [3:0]  mem_byte_en_o;
    logic        mem_ack_i;
    logic [31:0] mem_rd_data_i;

    l3_cache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(req0_valid_i), .req0_addr_i(req0_addr_i), .req0_wr_en_i(req0_wr_en_i),
        .req0_wr_data_i(req0_wr_data_i), .req0_byte_en_i(req0_byte_en_i),
        .req0_done_o(req0_done_o), .req0_rd_data_o(req0_rd_data_o), .req0_err_o(req0_err_o),
        .req1_valid_i(req1_valid_i), .req1_addr_i(req1_addr_i), .req1_wr_en_i(req1_wr_en_i),
        .req1_wr_data_i(req1_wr_data_i), .req1_byte_en_i(req1_byte_en_i),
        .req1_done_o(req1_done_o), .req1_rd_data_o(req1_rd_data_o), .req1_err_o(req1_err_o),
        .cache_addr_o(cache_addr_o), .cache_wr_en_o(cache_wr_en_o), .cache_wr_data_o(cache_wr_data_o),
        .cache_byte_en_o(cache_byte_en_o), .cache_mem_valid_o(cache_mem_valid_o),
        .cache_mem_data_o(cache_mem_data_o), .cache_hit_i(cache_hit_i), .cache_rd_data_i(cache_rd_data_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_byte_en_o(mem_byte_en_o), .mem_wr_data_o(mem_wr_data_o),
        .mem_ack_i(mem_ack_i), .mem_rd_data_i(mem_rd_data_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        port;
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          start;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mem_wait = 0;
    int mcnt = 0;
    logic [31:0] mem_data = 0;

    logic        saw_mem_req, saw_mem_we, saw_cache_be, saw_cache_wr, saw_fill;
    logic [31:0] fill_data, mem_addr_seen, mem_wd_seen;
    logic [3:0]  mem_be_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{req0_done_o, req1_done_o, req0_err_o, req1_err_o, req0_rd_data_o, req1_rd_data_o,
                 cache_addr_o, cache_wr_en_o, cache_wr_data_o, cache_byte_en_o, cache_mem_valid_o,
                 cache_mem_data_o, mem_req_o, mem_we_o, mem_addr_o, mem_byte_en_o, mem_wr_data_o};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory responder: acks after mem_wait full cycles of mem_req_o
    initial begin
        mem_ack_i = 0;
        mem_rd_data_i = 0;
        forever begin
            @(negedge clk);
            if (mem_req_o) begin
                if (mcnt == mem_wait) begin
                    mem_ack_i = 1;
                    mem_rd_data_i = mem_data;
                    mcnt = 0;
                end else begin
                    mem_ack_i = 0;
                    mcnt++;
                end
            end else begin
                mem_ack_i = 0;
                mcnt = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (cache_byte_en_o != 0) saw_cache_be = 1;
        if (cache_wr_en_o) saw_cache_wr = 1;
        if (cache_mem_valid_o) begin
            saw_fill = 1;
            fill_data = cache_mem_data_o;
        end
        if (mem_req_o) begin
            saw_mem_req = 1;
            mem_addr_seen = mem_addr_o;
            if (mem_we_o) begin
                saw_mem_we = 1;
                mem_be_seen = mem_be_o_sample();
                mem_wd_seen = mem_wr_data_o;
            end
        end
    end

    function automatic logic [3:0] mem_be_o_sample();
        return mem_byte_en_o;
    endfunction

    initial forever begin
        @(negedge clk);
        #2;
        if (rst_n && (req0_done_o || req1_done_o)) begin
            exp_t e;
            logic p;
            chk("dual_done", 32'(req0_done_o & req1_done_o), 32'd0);
            chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                p = req1_done_o;
                chk("done_port", 32'(p), 32'(e.port));
                chk("rd_data", p ? req1_rd_data_o : req0_rd_data_o, e.rd);
                chk("err", 32'(p ? req1_err_o : req0_err_o), 32'(e.err));
                chk("other_err", 32'(p ? req0_err_o : req1_err_o), 32'd0);
                if (e.lat >= 0) chk("latency", 32'(cyc - e.start), 32'(e.lat));
            end
        end
    end

    task automatic set_req(input logic p, input logic v, input logic [31:0] addr, input logic wr,
                           input logic [31:0] wd, input logic [3:0] be);
        if (p) begin
            req1_valid_i = v; req1_addr_i = addr; req1_wr_en_i = wr;
            req1_wr_data_i = wd; req1_byte_en_i = be;
        end else begin
            req0_valid_i = v; req0_addr_i = addr; req0_wr_en_i = wr;
            req0_wr_data_i = wd; req0_byte_en_i = be;
        end
    endtask

    task automatic issue(input logic p, input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input logic [3:0] be, input logic hit, input logic [31:0] crd, input int mw,
                         input logic [31:0] md, input logic [31:0] exp_rd, input logic exp_err,
                         input int exp_lat, input string tag);
        exp_t e;
        logic got;
        @(negedge clk);
        saw_mem_req = 0; saw_mem_we = 0; saw_cache_be = 0; saw_cache_wr = 0; saw_fill = 0;
        fill_data = 0; mem_addr_seen = 0; mem_wd_seen = 0; mem_be_seen = 0;
        cache_hit_i = hit; cache_rd_data_i = crd; mem_wait = mw; mem_data = md;
        e.port = p; e.rd = exp_rd; e.err = exp_err; e.lat = exp_lat; e.start = cyc;
        sbq.push_back(e);
        set_req(p, 1'b1, addr, wr, wd, be);
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (p ? req1_done_o : req0_done_o) begin
                got = 1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        set_req(p, 1'b0, 32'd0, 1'b0, 32'd0, 4'b0000);
    endtask

    initial begin
        int n;
        exp_t e;
        saw_mem_req = 0; saw_mem_we = 0; saw_cache_be = 0; saw_cache_wr = 0; saw_fill = 0;
        fill_data = 0; mem_addr_seen = 0; mem_wd_seen = 0; mem_be_seen = 0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'(any_out()), 32'd0);
        rst_n = 1;

        // Both ports valid continuously: grants must alternate 0,1,0,1
        @(negedge clk);
        cache_hit_i = 1; cache_rd_data_i = 32'hA0A0_0001;
        for (int i = 0; i < 4; i++) begin
            e.port = i[0]; e.rd = 32'hA0A0_0001; e.err = 0; e.lat = (i == 0) ? 2 : -1; e.start = cyc;
            sbq.push_back(e);
        end
        set_req(1'b0, 1'b1, 32'h10, 1'b0, 32'd0, 4'b1111);
        set_req(1'b1, 1'b1, 32'h20, 1'b0, 32'd0, 4'b1111);
        n = 0;
        for (int i = 0; i < 100 && n < 4; i++) begin
            @(negedge clk);
            #1;
            n += int'(req0_done_o) + int'(req1_done_o);
        end
        chk("arb_done_count", 32'(n), 32'd4);
        set_req(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 4'b0000);
        set_req(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 4'b0000);

        issue(1'b0, 32'h0000_0104, 1'b0, 32'd0, 4'b1111, 1'b1, 32'hDEAD_BEEF, 0, 32'd0,
              32'hDEAD_BEEF, 1'b0, 2, "load_hit");
        chk("load_hit_no_mem", 32'(saw_mem_req), 32'd0);

        issue(1'b1, 32'h0000_0200, 1'b0, 32'd0, 4'b0001, 1'b0, 32'hFFFF_FFFF, 3, 32'h1234_56A5,
              32'h0000_00A5, 1'b0, 7, "load_miss");
        chk("load_miss_fill", 32'(saw_fill), 32'd1);
        chk("load_miss_fill_data", fill_data, 32'h1234_56A5);
        chk("load_miss_mem_addr", mem_addr_seen, 32'h0000_0200);
        chk("load_miss_no_we", 32'(saw_mem_we), 32'd0);

        issue(1'b1, 32'h0000_0008, 1'b1, 32'hFFFF_BEEF, 4'b0011, 1'b1, 32'd0, 2, 32'd0,
              32'd0, 1'b0, 5, "store_hit");
        chk("store_hit_cache_wr", 32'(saw_cache_wr), 32'd1);
        chk("store_hit_mem_we", 32'(saw_mem_we), 32'd1);
        chk("store_hit_mem_be", 32'(mem_be_seen), 32'h3);
        chk("store_hit_mem_wd", mem_wd_seen, 32'hFFFF_BEEF);
        chk("store_hit_no_fill", 32'(saw_fill), 32'd0);

        issue(1'b0, 32'h0000_0040, 1'b1, 32'h0000_55AA, 4'b1111, 1'b0, 32'd0, 0, 32'h7777_0000,
              32'd0, 1'b0, 5, "store_miss_ack0");
        chk("store_miss_fill_data", fill_data, 32'h7777_0000);
        chk("store_miss_mem_wd", mem_wd_seen, 32'h0000_55AA);

        issue(1'b0, 32'h0000_0300, 1'b0, 32'd0, 4'b0011, 1'b0, 32'd0, 0, 32'hBEEF_1234,
              32'h0000_1234, 1'b0, 4, "load_miss_half");

        issue(1'b0, 32'h0000_0004, 1'b0, 32'd0, 4'b0101, 1'b1, 32'hCAFE_CAFE, 0, 32'd0,
              32'd0, 1'b1, 1, "illegal_be");
        chk("illegal_no_cache", 32'(saw_cache_be), 32'd0);
        chk("illegal_no_mem", 32'(saw_mem_req), 32'd0);

        // Reset while a memory read is outstanding
        @(negedge clk);
        cache_hit_i = 0; mem_wait = 1000;
        set_req(1'b0, 1'b1, 32'h0000_0500, 1'b0, 32'd0, 4'b1111);
        n = 0;
        for (int i = 0; i < 20 && !mem_req_o; i++) @(negedge clk);
        chk("rst_reached_memrd", 32'(mem_req_o), 32'd1);
        rst_n = 0;
        #1;
        chk("rst_mid_outputs", 32'(any_out()), 32'd0);
        set_req(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 4'b0000);
        @(negedge clk);
        rst_n = 1;

        issue(1'b0, 32'h0000_0600, 1'b0, 32'd0, 4'b1111, 1'b0, 32'd0, 1, 32'hCAFE_F00D,
              32'hCAFE_F00D, 1'b0, 5, "post_reset");

        repeat (5) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
